spi_gate_burst: RTL and testbench
=================================

Name: spi_gate_burst

Overview:
- Parametrised successor to the SPI host gateway.
- Bridges an external SPI host (SCLK/MOSI/MISO/nCS) to the internal port bus (RXD/TXD/ADDR/SEL/TXE/RXE).
- Adds configurable address and data widths, a synchronous reset, single-cycle RXE/TXE handshakes, a per-frame word counter, a frame-done strobe, and optional address auto-increment for burst access.
- Sits between the MCU SPI pins and the IOPort-style register ports.

Parameters:
- ADDR_W, 8: address phase length in bits; width of ADDR.
- DATA_W, 8: data word length in bits; width of RXD/TXD.
- WCNT_W, 8: width of the word counter WCNT.
- CS_FLT_TAPS, 3: nCS glitch-filter depth in CLK cycles (must be ≥2).
- AUTO_INC, 0: 1 means ADDR increments after every completed data word (burst mode); 0 means ADDR is fixed for the frame.

Ports:
- CLK, input, 1: global clock; all logic on its rising edge.
- RST, input, 1: synchronous, active-high reset.
- SCLK, input, 1: host SPI clock (asynchronous).
- MOSI, input, 1: host data in (asynchronous).
- MISO, output, 1: host data out, equal to the shift register MSB.
- nCS, input, 1: host chip select, active low (asynchronous).
- RXD, output, DATA_W: last received data word.
- TXD, input, DATA_W: word supplied by the addressed port for transmission.
- ADDR, output, ADDR_W: current port address.
- SEL, output, 1: high while a frame is active and the address phase is complete.
- TXE, output, 1: transmit enable; the addressed port must drive TXD while high.
- RXE, output, 1: one-cycle pulse; RXD holds a new valid word.
- WCNT, output, WCNT_W: completed data words in the current frame.
- DONE, output, 1: one-cycle pulse when SEL falls.

Behaviour:
- Reset (RST=1, synchronous) clears, on the next CLK edge:
  - all outputs (MISO, RXD, ADDR, SEL, TXE, RXE, WCNT, DONE) to 0;
  - the shift register, bit counter, CS filter and cs_in to 0.
- Reset dominates every other event. A frame in progress is abandoned silently: no RXE, no DONE.
- Input synchronisation:
  - SCLK and MOSI are registered once (sclk_in, data_in).
  - A sample edge is a cycle where sclk_in=1 and its previous value was 0.
- CS filter:
  - ~nCS shifts into a CS_FLT_TAPS register.
  - cs_in sets when all taps are 1 and clears when all taps are 0; otherwise it holds.
- Timing requirement on the host: SCLK high and low phases each ≥4 CLK; nCS setup to the first SCLK edge ≥ CS_FLT_TAPS+2 CLK. Behaviour outside these limits is undefined.
- States: IDLE, ADDR_PH, DATA_PH.
  - IDLE → ADDR_PH when cs_in rises.
  - Any state → IDLE when cs_in=0.
  - ADDR_PH: each sample edge shifts data_in into ADDR, MSB first. On the ADDR_W-th edge go to DATA_PH. SEL rises the cycle after that edge.
  - DATA_PH: each sample edge shifts data_in into the DATA_W shift register LSB, MSB first.
- Word completion: the DATA_W-th sample edge at cycle t produces:
  - t+1: RXD ← shift register, RXE=1 for exactly one cycle, WCNT += 1 (wraps modulo 2^WCNT_W). ADDR still holds the address of the word just received.
  - t+2: if AUTO_INC=1, ADDR += 1 (wraps modulo 2^ADDR_W). The bit counter is already 0.
  - t+2 and t+3: TXE=1 (transmit fetch, see below).
- Transmit fetch:
  - TXE is high for exactly 2 cycles, starting 1 cycle after SEL rises and 1 cycle after each RXE pulse.
  - The shift register loads TXD on the CLK edge that ends the second TXE cycle.
  - ADDR is stable throughout TXE, so a port may decode combinationally.
  - Any RXE pulse is never simultaneous with TXE.
- MISO always equals shift_reg[DATA_W-1].
  - It is undefined until the first load and does not change during ADDR_PH (the data register is not shifted in ADDR_PH).
- Deselect:
  - When cs_in falls, SEL drops on the next cycle, with DONE=1 for that one cycle.
  - WCNT holds its value until the next frame start, where it clears to 0.
  - A partial word (fewer than DATA_W edges) is discarded: no RXE, RXD unchanged.
  - A deselect during ADDR_PH gives neither SEL nor DONE.
- Simultaneous events:
  - If cs_in falls in the same cycle as the DATA_W-th sample edge, the word is discarded.
  - If a sample edge coincides with the TXD load, the load takes priority. This cannot occur within the timing limits.
- No internal timeouts. Frames are unbounded in length.

Test Plan:
1. Reset mid-frame: ADDR_W=8, DATA_W=8; send address 0x5A plus 4 bits, then assert RST for 1 cycle → all outputs 0 next cycle, no RXE, no DONE; a subsequent frame works normally.
2. Single write: address 0x12, data 0xA5, deselect → SEL=1 after the 8th address edge, one RXE pulse with RXD=0xA5 and ADDR=0x12, WCNT=1, DONE pulse once.
3. Read: address 0x30, TXD=0xC3 while TXE is high, clock 8 bits → MISO sampled on rising edges yields 1,1,0,0,0,0,1,1; exactly one TXE pair before the word and another pair after it.
4. Burst with AUTO_INC=1: address 0xFE, 3 data words 0x01, 0x02, 0x03 → RXE pulses at ADDR=0xFE, 0xFF, 0x00 (wrap); WCNT=3.
5. Wide config, ADDR_W=16, DATA_W=16: address 0x1234, data 0xBEEF → RXD=0xBEEF, ADDR=0x1234; a partial 5-bit second word followed by deselect → no second RXE, WCNT=1.
6. nCS glitch of 2 CLK low with CS_FLT_TAPS=3 → cs_in unchanged, no state change; a 1-cycle pulse on SCLK/MOSI while idle → no ADDR shift.

Source files
------------

// File: rtl/spi_gate_burst.sv
// spi_gate_burst: SPI host to internal port-bus gateway.
// Serial address phase, then data words; optional ADDR auto-increment.
// Ports:
//   CLK, RST         - system clock, synchronous active-high reset
//   SCLK, MOSI, nCS  - asynchronous SPI host inputs
//   MISO             - SPI data out (shift register MSB)
//   RXD, RXE         - received word and its one-cycle valid strobe
//   TXD, TXE         - transmit word from port, fetched while TXE high
//   ADDR, SEL        - port address and frame-active select
//   WCNT, DONE       - words completed in frame, end-of-frame strobe
module spi_gate_burst #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WCNT_W      = 8,
  parameter int CS_FLT_TAPS = 3,
  parameter int AUTO_INC    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              nCS,
  output logic [DATA_W-1:0] RXD,
  input  logic [DATA_W-1:0] TXD,
  output logic [ADDR_W-1:0] ADDR,
  output logic              SEL,
  output logic              TXE,
  output logic              RXE,
  output logic [WCNT_W-1:0] WCNT,
  output logic              DONE
);

  localparam int MAXW = (ADDR_W > DATA_W)
                      ? ADDR_W : DATA_W;
  localparam int BC_W = $clog2(MAXW) + 1;

  localparam logic [BC_W-1:0] ADDR_LAST =
    BC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0] DATA_LAST =
    BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_PH = 2'd1,
    DATA_PH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   r_sclk_in;
  logic                   r_sclk_d;
  logic                   r_data_in;
  logic [CS_FLT_TAPS-1:0] r_cs_sh;
  logic                   r_cs_in;
  logic [BC_W-1:0]        r_bcnt;
  logic [DATA_W-1:0]      r_shift;
  logic [DATA_W-1:0]      r_rxd;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_rxe;
  logic [WCNT_W-1:0]      r_wcnt;
  logic                   r_done;
  logic                   r_sel_q;
  logic                   r_tx1;
  logic                   r_tx2;

  logic              w_edge;
  logic              w_in_idle;
  logic              w_in_addr;
  logic              w_in_data;
  logic              w_frame_start;
  logic              w_addr_bit;
  logic              w_data_bit;
  logic              w_addr_last;
  logic              w_word_last;
  logic              w_sel;
  logic              w_txe_trig;
  logic              w_load;
  logic [DATA_W-1:0] w_shift_nxt;

  // Input registers: one stage for SCLK/MOSI, edge detect
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sclk_in <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_data_in <= 1'b0;
    end else begin
      r_sclk_in <= SCLK;
      r_sclk_d  <= r_sclk_in;
      r_data_in <= MOSI;
    end
  end

  assign w_edge = r_sclk_in & ~r_sclk_d;

  // Chip-select filter: cs_in only moves on a
  // unanimous tap vector, so short glitches are held out
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cs_sh <= '0;
      r_cs_in <= 1'b0;
    end else begin
      r_cs_sh <= {r_cs_sh[CS_FLT_TAPS-2:0], ~nCS};
      if (&r_cs_sh)
        r_cs_in <= 1'b1;
      else if (~|r_cs_sh)
        r_cs_in <= 1'b0;
    end
  end

  // Frame state register
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state and phase decode
  always_comb begin
    w_next    = r_state;
    w_in_idle = 1'b0;
    w_in_addr = 1'b0;
    w_in_data = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_idle = 1'b1;
        if (r_cs_in)
          w_next = ADDR_PH;
      end
      ADDR_PH: begin
        w_in_addr = 1'b1;
        if (!r_cs_in)
          w_next = IDLE;
        else if (w_edge && r_bcnt == ADDR_LAST)
          w_next = DATA_PH;
      end
      DATA_PH: begin
        w_in_data = 1'b1;
        if (!r_cs_in)
          w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_frame_start = w_in_idle & r_cs_in;
  assign w_addr_bit    = w_in_addr & w_edge & r_cs_in;
  assign w_data_bit    = w_in_data & w_edge & r_cs_in;
  assign w_addr_last   = w_addr_bit
                       & (r_bcnt == ADDR_LAST);
  assign w_word_last   = w_data_bit
                       & (r_bcnt == DATA_LAST);
  assign w_shift_nxt   = {r_shift[DATA_W-2:0],
                          r_data_in};

  assign w_sel      = w_in_data;
  // Fetch after SEL rises and after every received word
  assign w_txe_trig = (w_sel & ~r_sel_q) | r_rxe;
  assign w_load     = r_tx2;

  // Bit counter, shared by both phases
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bcnt <= '0;
    end else if (w_frame_start) begin
      r_bcnt <= '0;
    end else if (w_addr_bit) begin
      if (w_addr_last)
        r_bcnt <= '0;
      else
        r_bcnt <= r_bcnt + BC_W'(1);
    end else if (w_data_bit) begin
      if (w_word_last)
        r_bcnt <= '0;
      else
        r_bcnt <= r_bcnt + BC_W'(1);
    end
  end

  // Address register: serial load, then optional
  // post-word increment one cycle after RXE
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr <= '0;
    end else if (w_addr_bit) begin
      r_addr <= {r_addr[ADDR_W-2:0], r_data_in};
    end else if (AUTO_INC != 0 && r_rxe) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Data shift register: TXD load wins over a sample
  always_ff @(posedge CLK) begin
    if (RST)
      r_shift <= '0;
    else if (w_load)
      r_shift <= TXD;
    else if (w_data_bit)
      r_shift <= w_shift_nxt;
  end

  // Receive word, strobe and word counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rxd  <= '0;
      r_rxe  <= 1'b0;
      r_wcnt <= '0;
    end else begin
      r_rxe <= w_word_last;
      if (w_word_last)
        r_rxd <= w_shift_nxt;
      if (w_frame_start)
        r_wcnt <= '0;
      else if (w_word_last)
        r_wcnt <= r_wcnt + WCNT_W'(1);
    end
  end

  // Transmit fetch window and end-of-frame strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sel_q <= 1'b0;
      r_tx1   <= 1'b0;
      r_tx2   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sel_q <= w_sel;
      r_tx1   <= w_txe_trig & w_sel & r_cs_in;
      r_tx2   <= r_tx1 & r_cs_in;
      r_done  <= w_in_data & ~r_cs_in;
    end
  end

  assign MISO = r_shift[DATA_W-1];
  assign RXD  = r_rxd;
  assign ADDR = r_addr;
  assign SEL  = w_sel;
  assign TXE  = r_tx1 | r_tx2;
  assign RXE  = r_rxe;
  assign WCNT = r_wcnt;
  assign DONE = r_done;

endmodule

// File: tb/tb_spi_gate_burst.sv
// tb_spi_gate_burst: directed bench for spi_gate_burst.
// Two instances: 8/8 burst (A) and 16/16 fixed-address (B).
module tb_spi_gate_burst;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sclk  = 1'b0;
  logic        mosi  = 1'b0;
  logic        ncs_a = 1'b1;
  logic        ncs_b = 1'b1;
  logic [7:0]  txd_a = 8'hC3;
  logic [15:0] txd_b = 16'h0F0F;

  logic        miso_a, sel_a, txe_a, rxe_a, done_a;
  logic [7:0]  rxd_a, addr_a, wcnt_a;
  logic        miso_b, sel_b, txe_b, rxe_b, done_b;
  logic [15:0] rxd_b, addr_b;
  logic [7:0]  wcnt_b;

  always #5 clk = ~clk;

  spi_gate_burst #(
    .ADDR_W(8), .DATA_W(8), .WCNT_W(8),
    .CS_FLT_TAPS(3), .AUTO_INC(1)
  ) u_a (
    .CLK(clk), .RST(rst), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso_a), .nCS(ncs_a), .RXD(rxd_a),
    .TXD(txd_a), .ADDR(addr_a), .SEL(sel_a),
    .TXE(txe_a), .RXE(rxe_a), .WCNT(wcnt_a),
    .DONE(done_a)
  );

  spi_gate_burst #(
    .ADDR_W(16), .DATA_W(16), .WCNT_W(8),
    .CS_FLT_TAPS(3), .AUTO_INC(0)
  ) u_b (
    .CLK(clk), .RST(rst), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso_b), .nCS(ncs_b), .RXD(rxd_b),
    .TXD(txd_b), .ADDR(addr_b), .SEL(sel_b),
    .TXE(txe_b), .RXE(rxe_b), .WCNT(wcnt_b),
    .DONE(done_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Behavioural model: expected RXE records per frame
  typedef struct packed {
    logic [15:0] rxd;
    logic [15:0] addr;
    logic [7:0]  wcnt;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] m_addr[2];
  logic [15:0] m_mask[2];
  int          m_inc[2];
  int          m_wcnt[2];
  int          exp_done[2];
  int          exp_pairs[2];
  int          act_pairs[2];

  task automatic model_frame(input int d,
                             input logic [15:0] a);
    m_addr[d] = a;
    m_wcnt[d] = 0;
  endtask

  task automatic model_sel(input int d);
    exp_pairs[d]++;
  endtask

  task automatic model_word(input int d,
                            input logic [15:0] data);
    exp_t e;
    m_wcnt[d]++;
    e.rxd  = data;
    e.addr = m_addr[d];
    e.wcnt = 8'(m_wcnt[d]);
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
    exp_pairs[d]++;
    if (m_inc[d] != 0)
      m_addr[d] = (m_addr[d] + 16'd1) & m_mask[d];
  endtask

  task automatic model_end(input int d);
    exp_done[d]++;
  endtask

  // Per-cycle protocol checker
  logic        p_rxe[2];
  logic        p_sel[2];
  logic        p_done[2];
  logic        want_txe[2];
  int          run[2];
  logic [15:0] p_addr[2];

  task automatic cmp(input int d,
                     input logic rxe, input logic txe,
                     input logic sel, input logic done,
                     input logic [15:0] rxd,
                     input logic [15:0] addr,
                     input logic [7:0] wcnt);
    exp_t e;
    if (rst) begin
      p_rxe[d]    = 1'b0;
      p_sel[d]    = 1'b0;
      p_done[d]   = 1'b0;
      want_txe[d] = 1'b0;
      run[d]      = 0;
    end else begin
      if (rxe) begin
        chk($sformatf("rxe_txe_excl%0d", d), txe, 0);
        chk($sformatf("rxe_width%0d", d), p_rxe[d], 0);
        if ((d == 0 && q_a.size() == 0) ||
            (d == 1 && q_b.size() == 0)) begin
          chk($sformatf("rxe_expected%0d", d), 0, 1);
        end else begin
          if (d == 0) e = q_a.pop_front();
          else        e = q_b.pop_front();
          chk($sformatf("rxd%0d", d), rxd, e.rxd);
          chk($sformatf("rxe_addr%0d", d), addr, e.addr);
          chk($sformatf("wcnt%0d", d), wcnt, e.wcnt);
        end
      end
      if (done) begin
        chk($sformatf("done_expected%0d", d),
            exp_done[d] > 0, 1);
        chk($sformatf("done_width%0d", d), p_done[d], 0);
        chk($sformatf("done_sel_low%0d", d), sel, 0);
        if (exp_done[d] > 0) exp_done[d]--;
      end
      if (want_txe[d])
        chk($sformatf("txe_start%0d", d), txe, 1);
      want_txe[d] = rxe | (sel & ~p_sel[d]);
      if (txe) begin
        if (run[d] > 0)
          chk($sformatf("txe_addr_stable%0d", d),
              addr, p_addr[d]);
        run[d]++;
      end else if (run[d] > 0) begin
        chk($sformatf("txe_len%0d", d), run[d], 2);
        act_pairs[d]++;
        run[d] = 0;
      end
      p_rxe[d]  = rxe;
      p_sel[d]  = sel;
      p_done[d] = done;
      p_addr[d] = addr;
    end
  endtask

  always @(negedge clk) begin
    cmp(0, rxe_a, txe_a, sel_a, done_a,
        {8'h00, rxd_a}, {8'h00, addr_a}, wcnt_a);
    cmp(1, rxe_b, txe_b, sel_b, done_b,
        rxd_b, addr_b, wcnt_b);
  end

  // SPI host driver
  int cur = 0;

  task automatic send(input logic [15:0] v,
                      input int n,
                      output logic [15:0] mi);
    mi = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (4) @(negedge clk);
      mi = {mi[14:0], (cur == 0) ? miso_a : miso_b};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic begin_frame(input int d,
                             input logic [15:0] a);
    cur = d;
    model_frame(d, a);
    if (d == 0) ncs_a = 1'b0;
    else        ncs_b = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_frame(input int d);
    repeat (4) @(negedge clk);
    model_end(d);
    if (d == 0) ncs_a = 1'b1;
    else        ncs_b = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic [15:0] mi;

  initial begin
    m_mask[0] = 16'h00FF;
    m_mask[1] = 16'hFFFF;
    m_inc[0]  = 1;
    m_inc[1]  = 0;
    for (int d = 0; d < 2; d++) begin
      m_addr[d]    = '0;
      m_wcnt[d]    = 0;
      exp_done[d]  = 0;
      exp_pairs[d] = 0;
      act_pairs[d] = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset_a", {miso_a, rxd_a, addr_a, sel_a,
                    txe_a, rxe_a, wcnt_a, done_a}, 0);
    chk("reset_b", {miso_b, rxd_b, addr_b, sel_b,
                    txe_b, rxe_b, wcnt_b, done_b}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: reset mid-frame
    begin_frame(0, 16'h5A);
    send(16'h5A, 8, mi);
    model_sel(0);
    chk("t1_addr", addr_a, 8'h5A);
    send(16'hA, 4, mi);
    rst   = 1'b1;
    ncs_a = 1'b1;
    @(negedge clk);
    chk("t1_rst_a", {miso_a, rxd_a, addr_a, sel_a,
                     txe_a, rxe_a, wcnt_a, done_a}, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // 2: single write
    begin_frame(0, 16'h12);
    send(16'h12 >> 1, 7, mi);
    chk("t2_sel_pre", sel_a, 0);
    send(16'h12, 1, mi);
    chk("t2_sel_post", sel_a, 1);
    model_sel(0);
    model_word(0, 16'hA5);
    send(16'hA5, 8, mi);
    chk("t2_rxd", rxd_a, 8'hA5);
    chk("t2_wcnt", wcnt_a, 8'd1);
    end_frame(0);
    chk("t2_sel_end", sel_a, 0);
    chk("t2_done_seen", exp_done[0], 0);
    chk("t2_wcnt_hold", wcnt_a, 8'd1);

    // 3: read
    begin_frame(0, 16'h30);
    send(16'h30, 8, mi);
    model_sel(0);
    model_word(0, 16'h00);
    send(16'h00, 8, mi);
    chk("t3_miso", mi[7:0], 8'hC3);
    end_frame(0);
    chk("t3_pairs", act_pairs[0], exp_pairs[0]);

    // 4: burst with wrap
    begin_frame(0, 16'hFE);
    send(16'hFE, 8, mi);
    model_sel(0);
    for (int i = 1; i <= 3; i++) begin
      model_word(0, 16'(i));
      send(16'(i), 8, mi);
    end
    chk("t4_addr", addr_a, 8'h01);
    chk("t4_model_addr", m_addr[0], 16'h0001);
    chk("t4_wcnt", wcnt_a, 8'd3);
    end_frame(0);
    chk("t4_done_seen", exp_done[0], 0);

    // 5: wide config and partial word
    begin_frame(1, 16'h1234);
    send(16'h1234, 16, mi);
    model_sel(1);
    chk("t5_sel", sel_b, 1);
    model_word(1, 16'hBEEF);
    send(16'hBEEF, 16, mi);
    chk("t5_rxd", rxd_b, 16'hBEEF);
    chk("t5_addr", addr_b, 16'h1234);
    send(16'h16, 5, mi);
    end_frame(1);
    chk("t5_wcnt", wcnt_b, 8'd1);
    chk("t5_rxd_hold", rxd_b, 16'hBEEF);
    chk("t5_done_seen", exp_done[1], 0);
    chk("t5_pairs", act_pairs[1], exp_pairs[1]);
    chk("t5_a_idle_addr", addr_a, 8'h01);

    // 6: nCS glitch and idle SCLK pulse
    cur   = 0;
    ncs_a = 1'b0;
    repeat (2) @(negedge clk);
    ncs_a = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_sel", sel_a, 0);
    chk("t6_wcnt", wcnt_a, 8'd3);
    mosi = 1'b1;
    @(negedge clk);
    sclk = 1'b1;
    @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_addr", addr_a, 8'h01);
    chk("t6_model_addr", addr_a, m_addr[0][7:0]);

    repeat (4) @(negedge clk);
    chk("end_q_a", q_a.size(), 0);
    chk("end_q_b", q_b.size(), 0);
    chk("end_done_a", exp_done[0], 0);
    chk("end_pairs_a", act_pairs[0], exp_pairs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
